// File: rtl/game_pkg.sv
// ----------------------------------------------------------------------------
// game_pkg : wind constants, wind FSM states and LFSR step shared by game logic
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package game_pkg;

  localparam logic [6:0]  WIND_MAX   = 7'd100;
  localparam logic [6:0]  WIND_CALM  = 7'd50;
  localparam logic [15:0] LFSR_MASK  = 16'hB400;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DRAW = 2'd1,
    SLEW = 2'd2,
    DONE = 2'd3
  } wind_state_e;

  // One right-shifting Galois step; a nonzero value never maps to zero.
  function automatic logic [15:0] lfsr_next(input logic [15:0] v);
    return (v >> 1) ^ (v[0] ? LFSR_MASK : 16'h0000);
  endfunction

endpackage

`default_nettype wire

// File: rtl/lfsr16.sv
// ----------------------------------------------------------------------------
// lfsr16 : free-running 16-bit Galois LFSR, loads seed while rst is high
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module lfsr16
  import game_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] seed,
  output logic [15:0] out
);

  logic [15:0] value_q;
  logic [15:0] value_d;

  always_comb begin
    value_d = lfsr_next(value_q);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      value_q <= seed;
    end else begin
      value_q <= value_d;
    end
  end

  assign out = value_q;

endmodule

`default_nettype wire

// File: rtl/wind_gen.sv
// ----------------------------------------------------------------------------
// wind_gen : draws a random wind target and slews wind_force toward it
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module wind_gen
  import game_pkg::*;
#(
  parameter int unsigned SLEW_DIV  = 2,
  parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       new_turn,
  input  logic       frame_tick,
  output logic [6:0] wind_force,
  output logic [6:0] wind_target,
  output logic       busy,
  output logic       wind_done
);

  localparam logic [3:0] SLEW_LAST = 4'(SLEW_DIV - 1);

  logic [15:0] lfsr_out;
  logic        lfsr_unused;

  wind_state_e state_q, state_d;
  logic [6:0]  force_q, force_d;
  logic [6:0]  target_q, target_d;
  logic [3:0]  tick_cnt_q, tick_cnt_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;

  lfsr16 u_lfsr (
    .clk  (clk),
    .rst  (rst),
    .seed (LFSR_SEED),
    .out  (lfsr_out)
  );

  // Only the low seven bits form a wind sample; the rest only feed the shift.
  assign lfsr_unused = ^lfsr_out[15:7];

  always_comb begin
    state_d    = state_q;
    force_d    = force_q;
    target_d   = target_q;
    tick_cnt_d = tick_cnt_q;
    case (state_q)
      IDLE: begin
        if (new_turn) state_d = DRAW;
      end
      DRAW: begin
        if (lfsr_out[6:0] <= WIND_MAX) begin
          target_d   = lfsr_out[6:0];
          tick_cnt_d = 4'd0;
          state_d    = SLEW;
        end
      end
      SLEW: begin
        if (force_q == target_q) begin
          state_d = DONE;
        end else if (frame_tick) begin
          if (tick_cnt_q == SLEW_LAST) begin
            tick_cnt_d = 4'd0;
            force_d    = (force_q < target_q) ? force_q + 7'd1 : force_q - 7'd1;
          end else begin
            tick_cnt_d = tick_cnt_q + 4'd1;
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    busy_d = (state_d != IDLE);
    done_d = (state_d == DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      force_q    <= WIND_CALM;
      target_q   <= WIND_CALM;
      tick_cnt_q <= 4'd0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      force_q    <= force_d;
      target_q   <= target_d;
      tick_cnt_q <= tick_cnt_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  assign wind_force  = force_q;
  assign wind_target = target_q;
  assign busy        = busy_q;
  assign wind_done   = done_q;

endmodule

`default_nettype wire

// File: tb/tb_wind_gen.sv
// ----------------------------------------------------------------------------
// tb_wind_gen : directed self-checking bench for wind_gen
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tb_wind_gen;

  logic clk;
  logic rst;
  logic frame_tick;
  logic nt_a, nt_b, nt_c, nt_d;

  logic [6:0] force_a, force_b, force_c, force_d;
  logic [6:0] target_a, target_b, target_c, target_d;
  logic       busy_a, busy_b, busy_c, busy_d;
  logic       done_a, done_b, done_c, done_d;

  int errors = 0;
  int checks = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // a: defaults; b: step(seed)=0x0061 -> 97; c: step(seed)=0x007F -> 127;
  // d: step(seed)=0x0032 -> 50.
  wind_gen u_a (
    .clk(clk), .rst(rst), .new_turn(nt_a), .frame_tick(frame_tick),
    .wind_force(force_a), .wind_target(target_a), .busy(busy_a), .wind_done(done_a)
  );

  wind_gen #(.SLEW_DIV(1), .LFSR_SEED(16'h00C2)) u_b (
    .clk(clk), .rst(rst), .new_turn(nt_b), .frame_tick(frame_tick),
    .wind_force(force_b), .wind_target(target_b), .busy(busy_b), .wind_done(done_b)
  );

  wind_gen #(.SLEW_DIV(2), .LFSR_SEED(16'h00FE)) u_c (
    .clk(clk), .rst(rst), .new_turn(nt_c), .frame_tick(frame_tick),
    .wind_force(force_c), .wind_target(target_c), .busy(busy_c), .wind_done(done_c)
  );

  wind_gen #(.SLEW_DIV(2), .LFSR_SEED(16'h0064)) u_d (
    .clk(clk), .rst(rst), .new_turn(nt_d), .frame_tick(frame_tick),
    .wind_force(force_d), .wind_target(target_d), .busy(busy_d), .wind_done(done_d)
  );

  function automatic logic [15:0] model_step(input logic [15:0] v);
    return (v >> 1) ^ (v[0] ? 16'hB400 : 16'h0000);
  endfunction

  // First accepted sample when new_turn coincides with reset release.
  function automatic logic [6:0] model_draw(input logic [15:0] seed, output int rejects);
    logic [15:0] m;
    m = model_step(seed);
    rejects = 0;
    for (int i = 0; i < 64; i++) begin
      if (m[6:0] <= 7'd100) break;
      m = model_step(m);
      rejects++;
    end
    return m[6:0];
  endfunction

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [6:0] exp_t;
    logic [6:0] exp_f;
    int         rej;

    rst = 1'b1; frame_tick = 1'b0;
    nt_a = 1'b0; nt_b = 1'b0; nt_c = 1'b0; nt_d = 1'b0;
    repeat (3) tick();

    // Reset values
    chk("rst_force",  16'(force_a), 16'd50);
    chk("rst_target", 16'(target_a), 16'd50);
    chk("rst_busy",   16'(busy_a), 16'd0);
    chk("rst_done",   16'(done_a), 16'd0);
    chk("rst_lfsr_a", u_a.u_lfsr.out, 16'hACE1);
    chk("rst_lfsr_b", u_b.u_lfsr.out, 16'h00C2);

    // Draw with default seed
    exp_t = model_draw(16'hACE1, rej);
    rst = 1'b0; nt_a = 1'b1;
    tick();
    nt_a = 1'b0;
    chk("draw_busy", 16'(busy_a), 16'd1);
    repeat (rej) begin
      tick();
      chk("draw_reject_hold", 16'(target_a), 16'd50);
    end
    tick();
    chk("draw_target", 16'(target_a), 16'(exp_t));
    chk("draw_busy_slew", 16'(busy_a), 16'd1);

    // SLEW_DIV=2: first frame_tick only counts, second one steps
    exp_f = (exp_t > 7'd50) ? 7'd51 : 7'd49;
    frame_tick = 1'b1;
    tick();
    chk("slew_div_hold", 16'(force_a), 16'd50);
    tick();
    frame_tick = 1'b0;
    chk("slew_div_step", 16'(force_a), 16'(exp_f));

    // new_turn during SLEW is ignored
    nt_a = 1'b1;
    tick();
    nt_a = 1'b0;
    chk("ignore_target", 16'(target_a), 16'(exp_t));
    chk("ignore_busy", 16'(busy_a), 16'd1);

    // Abort mid-SLEW
    rst = 1'b1;
    tick();
    chk("abort_force", 16'(force_a), 16'd50);
    chk("abort_busy", 16'(busy_a), 16'd0);
    chk("abort_done", 16'(done_a), 16'd0);

    // Full slew 50 -> 97 with SLEW_DIV=1
    rst = 1'b0; nt_b = 1'b1;
    tick();
    nt_b = 1'b0;
    chk("abort_done_after", 16'(done_a), 16'd0);
    tick();
    chk("slew_target", 16'(target_b), 16'd97);
    frame_tick = 1'b1;
    for (int i = 0; i < 47; i++) begin
      tick();
      chk("slew_step", 16'(force_b), 16'(51 + i));
      chk("slew_no_early_done", 16'(done_b), 16'd0);
    end
    frame_tick = 1'b0;
    tick();
    chk("slew_done_pulse", 16'(done_b), 16'd1);
    chk("slew_done_busy", 16'(busy_b), 16'd1);
    tick();
    chk("slew_done_clear", 16'(done_b), 16'd0);
    chk("slew_idle_busy", 16'(busy_b), 16'd0);
    chk("slew_final_force", 16'(force_b), 16'd97);

    // Reset wins over new_turn; then rejection (c) and equal target (d)
    rst = 1'b1; nt_c = 1'b1; nt_d = 1'b1;
    tick();
    chk("rst_prio_busy_c", 16'(busy_c), 16'd0);
    chk("rst_prio_busy_d", 16'(busy_d), 16'd0);
    chk("rst_lfsr_c", u_c.u_lfsr.out, 16'h00FE);
    rst = 1'b0;
    tick();
    nt_c = 1'b0; nt_d = 1'b0;
    chk("rej_busy_draw", 16'(busy_c), 16'd1);
    tick();
    chk("rej_hold_target", 16'(target_c), 16'd50);
    chk("rej_hold_busy", 16'(busy_c), 16'd1);
    chk("eq_busy_slew", 16'(busy_d), 16'd1);
    chk("eq_no_done_yet", 16'(done_d), 16'd0);
    tick();
    chk("rej_target", 16'(target_c), 16'd63);
    chk("eq_done_pulse", 16'(done_d), 16'd1);
    chk("eq_force", 16'(force_d), 16'd50);
    tick();
    chk("eq_done_clear", 16'(done_d), 16'd0);
    chk("eq_idle_busy", 16'(busy_d), 16'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/wind_gen.md
WIND_GEN -- requirements
Module: wind_gen

Interface
REQ-001 SHALL have parameter SLEW_DIV, default 2: number of frame_tick pulses per 1-unit step of wind_force (legal 1..15).
REQ-002 SHALL have parameter LFSR_SEED, default 16'hACE1: LFSR reset value (must be nonzero).
REQ-003 SHALL have port clk, input, 1: system clock, the single clock of the block.
REQ-004 SHALL have port rst, input, 1: reset, synchronous, active-high.
REQ-005 SHALL have port new_turn, input, 1: one-cycle pulse that requests a new wind value.
REQ-006 SHALL have port frame_tick, input, 1: one-cycle pulse, once per video frame.
REQ-007 SHALL have port wind_force, output, 7: displayed wind (0..100; 50 = calm; lower = indicator further right).
REQ-008 SHALL have port wind_target, output, 7: most recently accepted random target (0..100).
REQ-009 SHALL have port busy, output, 1: high in any state other than IDLE.
REQ-010 SHALL have port wind_done, output, 1: one-cycle pulse when wind_force reaches wind_target.

Function
REQ-011 SHALL contain a 16-bit Galois LFSR (mask 16'hB400) that advances every clk cycle while not in reset and never holds zero.
REQ-012 SHALL implement FSM states IDLE, DRAW, SLEW, DONE, with all outputs registered.
REQ-013 IDLE: new_turn=1 -> DRAW; otherwise stay; frame_tick is ignored.
REQ-014 DRAW: sample lfsr[6:0]; if <=100, load wind_target and go to SLEW; if >100, reject and resample next cycle in DRAW.
REQ-015 SLEW: 4-bit tick counter counts frame_tick pulses; on the pulse where count==SLEW_DIV-1, clear the counter and step wind_force by +1 or -1 toward wind_target.
REQ-016 SLEW: when wind_force==wind_target (checked every cycle, including on entry), go to DONE with no further step.
REQ-017 DONE: assert wind_done for exactly this one cycle; go to IDLE.
REQ-018 new_turn outside IDLE SHALL be ignored; it is not queued.
REQ-019 Target equal to current wind: SLEW->DONE on the cycle after entry, with zero steps.
REQ-020 wind_force SHALL never leave 0..100; step arithmetic uses 7-bit unsigned with no wrap.
REQ-021 Latency from new_turn to busy=1 SHALL be 1 cycle; total settle time is |target-start|*SLEW_DIV frame_ticks plus DRAW cycles plus 2.
REQ-022 The tick counter SHALL clear on entry to SLEW.

Reset
REQ-023 rst=1 SHALL force: state IDLE, wind_force 50, wind_target 50, busy 0, wind_done 0, tick counter 0, LFSR to LFSR_SEED.
REQ-024 rst SHALL take priority over new_turn and frame_tick in the same cycle.
REQ-025 rst during DRAW or SLEW SHALL abort the operation; wind_done SHALL NOT pulse.

Structure
REQ-026 WIND_MAX (100), WIND_CALM (50) and the FSM state enum SHALL live in shared package game_pkg; the wind indicator renderer imports the same constants.
REQ-027 The LFSR SHALL be a sub-module lfsr16 (clk, rst, seed, out), instantiated once.
REQ-028 wind_force SHALL be the sole interface to the wind indicator; no VGA signals enter this block.

Verification
REQ-029 Reset: assert rst for 3 cycles -> wind_force=50, wind_target=50, busy=0, wind_done=0, LFSR=16'hACE1.
REQ-030 Draw: new_turn after reset, with the bench LFSR model -> wind_target equals the model's first sample <=100 and busy=1 the next cycle.
REQ-031 Slew: SLEW_DIV=1, start 50, forced LFSR seed giving target 97 -> 47 increments, one per frame_tick, then a single wind_done pulse and busy=0 the cycle after.
REQ-032 Rejection: seed with lfsr[6:0]=127 at sample -> DRAW persists at least 1 extra cycle, and the accepted target is <=100.
REQ-033 Ignore/abort: new_turn during SLEW -> wind_target unchanged; rst mid-SLEW -> wind_force=50 next cycle and no wind_done.
REQ-034 Equal target: target==50 from calm -> zero steps, wind_done 2 cycles after leaving DRAW.
